// File: rtl/dmem_responder.sv
// Load/store data-memory responder: little-endian word RAM, programmable wait states,
// ready/busy/err handshake. Define DMEM_ACCESS_COUNT_EN to add rd_count/wr_count outputs.

module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic              err
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int WORDS = 2 ** (ADDR_W - 2);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_rd, lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_f3;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] mem [WORDS];

  logic              a_rd, a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_f3;
  logic [DATA_W-1:0] a_data;
  logic              go, do_access, bad;
  logic [DATA_W-1:0] word, shifted, load_val, wshift;
  logic [3:0]        be;

  // With zero wait states the access happens on the sampling edge, so it uses the live inputs.
  always_comb begin
    if (state == IDLE) begin
      a_rd   = rd;
      a_wr   = wr;
      a_addr = addr;
      a_f3   = funct3;
      a_data = wr_data;
    end else begin
      a_rd   = lat_rd;
      a_wr   = lat_wr;
      a_addr = lat_addr;
      a_f3   = lat_f3;
      a_data = lat_data;
    end
  end

  assign go        = (state == IDLE) && (rd || wr);
  assign do_access = (WAIT_CYCLES == 0) ? go : ((state == WAIT) && (cnt == 4'd1));
  assign ready     = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    bad = 1'b0;
    if (a_rd && a_wr)
      bad = 1'b1;
    else if (a_rd)
      bad = (a_f3 == 3'b011) || (a_f3 == 3'b110) || (a_f3 == 3'b111);
    else
      bad = a_f3[2] || (a_f3[1:0] == 2'b11);
    if ((a_f3[1:0] == 2'b01) && a_addr[0])
      bad = 1'b1;
    if ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00))
      bad = 1'b1;
  end

  always_comb begin
    word    = mem[a_addr[ADDR_W-1:2]];
    shifted = word >> {a_addr[1:0], 3'b000};
    wshift  = a_data << {a_addr[1:0], 3'b000};
    case (a_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = word;
    endcase
    case (a_f3[1:0])
      2'b00:   be = 4'b0001 << a_addr[1:0];
      2'b01:   be = 4'b0011 << a_addr[1:0];
      default: be = 4'b1111;
    endcase
  end

  // A reset edge wins over a store that would otherwise land on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && do_access && a_wr && !bad) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          mem[a_addr[ADDR_W-1:2]][8*i +: 8] <= wshift[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rd_data  <= '0;
      err      <= 1'b0;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_f3   <= 3'd0;
      lat_data <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            lat_rd   <= rd;
            lat_wr   <= wr;
            lat_addr <= addr;
            lat_f3   <= funct3;
            lat_data <= wr_data;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (do_access) begin
        err <= bad;
        if (a_rd && !a_wr && !bad)
          rd_data <= load_val;
      end
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (do_access && !bad) begin
      if (a_rd && rd_count != 16'hFFFF)
        rd_count <= rd_count + 16'd1;
      if (a_wr && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference memory;
// a second zero-wait instance covers back-to-back held requests.

module tb_dmem_responder;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic [8:0]  addr = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        ready, busy, err;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [8:0]  addr1 = '0;
  logic [2:0]  funct3_1 = 3'b010;
  logic [31:0] wr_data1 = '0;
  logic [31:0] rd_data1;
  logic        ready1, busy1, err1;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] rd_count, wr_count, rd_count1, wr_count1;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .funct3(funct3),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .busy(busy), .err(err)
`ifdef DMEM_ACCESS_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  dmem_responder #(.WAIT_CYCLES(0)) u_zero (
    .clk(clk), .reset(reset), .rd(rd1), .wr(wr1), .addr(addr1), .funct3(funct3_1),
    .wr_data(wr_data1), .rd_data(rd_data1), .ready(ready1), .busy(busy1), .err(err1)
`ifdef DMEM_ACCESS_COUNT_EN
    , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
  );

  typedef struct {
    int          cycle;
    logic        is_err;
    logic        is_load;
    logic        is_store;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [512];
  int          cyc = 0;
  int          total = 0, passed = 0;
  int          busy_from = -1, busy_until = -1;
  logic [31:0] last_rd = '0;
  bit          mon_active = 1'b0;
  int          model_rd_cnt = 0, model_wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected)
      passed++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
  endtask

  function automatic bit model_err(input bit r, input bit w, input logic [8:0] a, input logic [2:0] f);
    int size;
    if (r && w) return 1'b1;
    if (r && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b1;
    if (w && f > 3'd2) return 1'b1;
    size = 1 << f[1:0];
    return (int'(a) % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f);
    int size;
    logic [31:0] v;
    size = 1 << f[1:0];
    v = '0;
    for (int i = 0; i < size; i++)
      v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (!f[2] && v[8*size-1])
      for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Called at posedge+1 while the DUT is idle; returns with the DUT idle again.
  task automatic applyStimulus(input bit r, input bit w, input logic [8:0] a, input logic [2:0] f,
                               input logic [31:0] d, input int hold);
    exp_t e;
    int size;
    rd = r; wr = w; addr = a; funct3 = f; wr_data = d;
    e.cycle    = cyc + WAITC + 1;
    e.is_err   = model_err(r, w, a, f);
    e.is_load  = r && !e.is_err;
    e.is_store = w && !e.is_err;
    e.data     = e.is_load ? model_load(a, f) : 32'd0;
    if (e.is_store) begin
      size = 1 << f[1:0];
      for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    end
    busy_from  = cyc + 1;
    busy_until = cyc + WAITC + 1;
    q.push_back(e);
    repeat (hold) begin @(posedge clk); #1; end
    rd = 1'b0; wr = 1'b0;
    while (cyc <= busy_until) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: pops one expectation per ready pulse and tracks held outputs.
  always @(negedge clk) begin
    exp_t e;
    if (mon_active) begin
      if (ready) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_ready", {31'd0, ready}, 32'd0);
        end else begin
          e = q.pop_front();
          checkOutput("latency", cyc, e.cycle);
          checkOutput("err", {31'd0, err}, {31'd0, e.is_err});
          if (e.is_load) begin
            last_rd = e.data;
            model_rd_cnt++;
          end
          if (e.is_store) model_wr_cnt++;
        end
      end else begin
        if (q.size() > 0 && cyc >= q[0].cycle) begin
          checkOutput("missing_ready", {31'd0, ready}, 32'd1);
          void'(q.pop_front());
        end
        checkOutput("err_idle", {31'd0, err}, 32'd0);
      end
      checkOutput("rd_data", rd_data, last_rd);
      checkOutput("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from && cyc <= busy_until)});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f, a, size, c, wait_cnt;
    bit r, w;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_active = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 128; i++)
      applyStimulus(1'b0, 1'b1, 9'(i * 4), 3'b010, $urandom, 1);

    applyStimulus(1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 1);
    applyStimulus(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, 1);
    applyStimulus(1'b0, 1'b1, 9'h011, 3'b000, 32'h00000055, 2);
    applyStimulus(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h013, 3'b000, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h013, 3'b100, 32'h0, 3);
    applyStimulus(1'b1, 1'b0, 9'h012, 3'b001, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h010, 3'b101, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h006, 3'b010, 32'h0, 1);
    applyStimulus(1'b0, 1'b1, 9'h005, 3'b001, 32'hCAFEF00D, 1);
    applyStimulus(1'b1, 1'b0, 9'h004, 3'b010, 32'h0, 1);
    applyStimulus(1'b1, 1'b1, 9'h010, 3'b010, 32'h11111111, 1);
    applyStimulus(1'b1, 1'b0, 9'h010, 3'b011, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h010, 3'b010, 32'h0, 1);

    // Reset while the store to 0x020 is still waiting: nothing may reach the RAM.
    c = cyc;
    wr = 1'b1; addr = 9'h020; funct3 = 3'b010; wr_data = 32'h12345678;
    busy_from = c + 1; busy_until = c + 3;
    @(posedge clk); #1;
    wr = 1'b0; reset = 1'b1; busy_until = c + 1;
    @(posedge clk); #1;
    last_rd = '0; model_rd_cnt = 0; model_wr_cnt = 0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 9'h020, 3'b010, 32'h0, 1);

    applyStimulus(1'b1, 1'b0, 9'h030, 3'b010, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h031, 3'b000, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h032, 3'b101, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 9'h033, 3'b010, 32'h0, 1);

    for (int n = 0; n < 250; n++) begin
      f = $urandom_range(0, 7);
      a = $urandom_range(0, 511);
      size = 1 << f[1:0];
      if ($urandom_range(0, 9) < 7) a = a - (a % size);
      w = $urandom_range(0, 1);
      r = !w || ($urandom_range(0, 15) == 0);
      applyStimulus(r, w, 9'(a), 3'(f), $urandom, $urandom_range(1, WAITC + 1));
    end

    // Zero-wait instance: a store, then a load held high; ready every other cycle.
    c = cyc;
    wr1 = 1'b1; addr1 = 9'h000; funct3_1 = 3'b010; wr_data1 = 32'hA5A50F0F;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("zw_ready", {31'd0, ready1}, 32'(k % 2));
      checkOutput("zw_busy", {31'd0, busy1}, 32'(k % 2));
      checkOutput("zw_err", {31'd0, err1}, 32'd0);
      if (k >= 3 && (k % 2) == 1) checkOutput("zw_rd_data", rd_data1, 32'hA5A50F0F);
      @(posedge clk); #1;
      if (cyc == c + 1) begin
        wr1 = 1'b0; rd1 = 1'b1;
      end
    end
    rd1 = 1'b0;

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
    checkOutput("drain", q.size(), 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
    @(negedge clk);
    checkOutput("rd_count", {16'd0, rd_count}, model_rd_cnt);
    checkOutput("wr_count", {16'd0, wr_count}, model_wr_cnt);
`endif
    mon_active = 1'b0;
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port (`wr`, `rd`, `addr`, `wr_data`, `rd_data`).
- Holds a word-organised, little-endian data RAM with byte/half/word access selected by `funct3`.
- Inserts a programmable number of wait states, returns a one-cycle `ready` per request and drives `busy` so the core can stall.
- Flags misaligned or illegal accesses on `err` instead of touching memory.

Parameters:
- DATA_W, 32, data width (fixed at 32 for RV32).
- ADDR_W, 9, byte-address width; memory depth = 2**ADDR_W bytes = 128 words.
- WAIT_CYCLES, 2, wait states inserted before the access; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rd  in  1  load request.
- wr  in  1  store request.
- addr  in  ADDR_W  byte address.
- funct3  in  3  access size/sign, RV32I encoding.
- wr_data  in  DATA_W  store data, right-aligned.
- rd_data  out  DATA_W  load result, extended per funct3; held until the next completed load.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in flight.
- err  out  1  one-cycle error pulse, coincident with ready.

Behaviour:
- Reset values:
  - state = IDLE.
  - rd_data = 0, ready = 0, busy = 0, err = 0, wait counter = 0.
  - RAM contents are NOT cleared.
- FSM states:
  - IDLE: requests are sampled only here.
    - On a rising edge with `rd|wr` = 1, latch addr, funct3, wr_data and direction.
    - Go to WAIT with cnt = WAIT_CYCLES, or go directly to RESP if WAIT_CYCLES = 0 (access performed on that same edge).
  - WAIT: cnt decrements each edge. The edge on which cnt == 1 performs the access and enters RESP.
  - RESP: ready = 1 for exactly this cycle; next edge returns to IDLE.
- Timing:
  - Latency is WAIT_CYCLES+1 cycles from the request cycle to the ready cycle.
  - Minimum request spacing is WAIT_CYCLES+2 cycles.
- busy = (state != IDLE), decoded from the registered state.
  - Requests presented while busy are ignored; they are not queued.
  - The core re-presents a request after it sees ready.
- Loads (addr word index = addr[ADDR_W-1:2], byte lane = addr[1:0]):
  - 000 lb: sign-extend the byte at the lane.
  - 001 lh: sign-extend the half at addr[1].
  - 010 lw: full word.
  - 100 lbu: zero-extend the byte at the lane.
  - 101 lhu: zero-extend the half at addr[1].
- Stores:
  - 000 sb: write wr_data[7:0] to the addressed byte lane only.
  - 001 sh: write wr_data[15:0] to the addressed half only.
  - 010 sw: write the full word.
  - Unwritten lanes are unchanged.
- Errors (err = 1 in the RESP cycle, no RAM change, rd_data unchanged):
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Load funct3 in {011, 110, 111}; store funct3 not in {000, 001, 010}.
  - rd and wr both high when sampled.
  - Error requests take the same latency as normal requests.
- Store completion: ready pulses and rd_data holds its previous value.
- Reset mid-operation:
  - Any state returns to IDLE on the reset edge and the pending request is discarded.
  - A store not yet performed leaves the RAM unchanged.
  - A store already performed stays in the RAM.
- Address wrap: none. addr covers the array exactly, so no out-of-range case exists.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- With the macro defined:
  - Add outputs rd_count[15:0] and wr_count[15:0].
  - Each counter increments on the RESP cycle of a successful load or store respectively.
  - Error responses are not counted.
  - Counters saturate at 16'hFFFF and clear on reset.
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=2: sw addr=0x010 data=0xDEADBEEF, then lw addr=0x010 -> ready exactly 3 cycles after each request; rd_data = 0xDEADBEEF; busy high for 3 cycles per request.
- After word 0x010 = 0xDEADBEEF: sb addr=0x011 data=0x55, then lw 0x010 -> 0xDEAD55EF. lb 0x013 -> 0xFFFFFFDE. lbu 0x013 -> 0x000000DE. lh 0x012 -> 0xFFFFDEAD. lhu 0x010 -> 0x000055EF.
- lw addr=0x006 -> err=1 and ready=1 in the same cycle; rd_data keeps its prior value. sh addr=0x005 -> err=1 and the word at 0x004 is unchanged.
- rd=1 and wr=1 together -> err pulse, no RAM change. Load funct3=011 -> err pulse.
- Assert reset during WAIT of sw 0x020=0x12345678 -> outputs are 0 next cycle, no ready pulse; a later lw 0x020 returns the old contents.
- WAIT_CYCLES=0 with a request held high continuously -> ready on cycles 1, 3, 5…; busy toggles. With DMEM_ACCESS_COUNT_EN, 3 loads + 1 misaligned load -> rd_count = 3.
